// File: rtl/stim_pkg.sv
// Shared constants and types for the RV32I instruction stimulus generator.
package stim_pkg;

    localparam logic [6:0]  OpcOpImm = 7'b0010011;
    localparam logic [6:0]  OpcOp    = 7'b0110011;
    localparam logic [31:0] NopInstr = 32'h0000_0013;
    localparam logic [31:0] LfsrPoly = 32'h8020_0003;

    typedef enum logic [1:0] {
        ModeItype = 2'd0,
        ModeRtype = 2'd1,
        ModeMixed = 2'd2,
        ModeNop   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Right-shifting Galois step: feedback taps applied when the bit shifted out is 1.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LfsrPoly : 32'h0);
    endfunction

endpackage

// File: rtl/stim_lfsr.sv
// 32-bit Galois LFSR that advances only when stepped; a zero seed is forced to 1.
module stim_lfsr
    import stim_pkg::*;
#(
    parameter logic [31:0] SEED = 32'd158
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    output logic [31:0] state
);

    localparam logic [31:0] InitState = (SEED == 32'd0) ? 32'd1 : SEED;

    logic [31:0] r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= InitState;
        end else if (step) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign state = r_state;

endmodule

// File: rtl/instr_stim_gen.sv
// Pseudo-random RV32I I/R-type instruction generator with a valid/ready output stream.
module instr_stim_gen
    import stim_pkg::*;
#(
    parameter logic [31:0] SEED     = 32'd158,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] max_count,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [31:0]      out_instr,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    localparam logic [4:0] RegMask = 5'(NUM_REGS - 1);

    state_e           r_fsm;
    mode_e            r_mode;
    logic [CNT_W-1:0] r_max;
    logic [CNT_W-1:0] r_count;
    logic             r_valid;
    logic             r_done;

    logic             w_step;
    logic [31:0]      w_state;
    logic [CNT_W-1:0] w_count_nxt;

    logic [11:0]      w_imm;
    logic [4:0]       w_rs1;
    logic [4:0]       w_rs2;
    logic [4:0]       w_rd;
    logic [2:0]       w_funct3;
    logic [6:0]       w_funct7;
    logic [31:0]      w_itype;
    logic [31:0]      w_rtype;
    logic [31:0]      w_instr;

    assign w_step = r_valid & out_ready;

    stim_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (w_step),
        .state (w_state)
    );

    always_comb begin
        w_funct3 = w_state[19:17];
        w_rs1    = w_state[16:12] & RegMask;
        w_rd     = w_state[24:20] & RegMask;
        w_rs2    = w_state[29:25] & RegMask;

        // Shift-immediates only allow shamt plus the SRAI bit.
        unique case (w_funct3)
            3'd1:    w_imm = w_state[11:0] & 12'h01F;
            3'd5:    w_imm = w_state[11:0] & 12'h41F;
            default: w_imm = w_state[11:0];
        endcase

        if (w_state[30] && (w_funct3 == 3'd0 || w_funct3 == 3'd5)) begin
            w_funct7 = 7'h20;
        end else begin
            w_funct7 = 7'h00;
        end

        w_itype = {w_imm, w_rs1, w_funct3, w_rd, OpcOpImm};
        w_rtype = {w_funct7, w_rs2, w_rs1, w_funct3, w_rd, OpcOp};

        unique case (r_mode)
            ModeItype: w_instr = w_itype;
            ModeRtype: w_instr = w_rtype;
            ModeMixed: w_instr = w_state[31] ? w_rtype : w_itype;
            default:   w_instr = NopInstr;
        endcase
    end

    // Saturates only matter for unlimited runs; bounded runs stop at max_count.
    assign w_count_nxt = (&r_count) ? r_count : r_count + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm   <= StIdle;
            r_mode  <= ModeItype;
            r_max   <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_fsm)
                StIdle, StDone: begin
                    if (start) begin
                        r_fsm   <= StRun;
                        r_mode  <= mode_e'(mode);
                        r_max   <= max_count;
                        r_count <= '0;
                        r_valid <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                StRun: begin
                    if (w_step) begin
                        r_count <= w_count_nxt;
                        if (r_max != '0 && w_count_nxt == r_max) begin
                            r_fsm   <= StDone;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_fsm   <= StIdle;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_valid;
    assign out_instr = r_valid ? w_instr : NopInstr;
    assign count     = r_count;
    assign done      = r_done;

endmodule

// File: tb/tb_instr_stim_gen.sv
// Directed self-checking bench for instr_stim_gen with hand-computed LFSR/decode vectors.
module tb_instr_stim_gen;

    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             reset;
    logic             start;
    logic [1:0]       mode;
    logic [CNT_W-1:0] max_count;
    logic             out_ready;

    logic             out_valid;
    logic [31:0]      out_instr;
    logic [CNT_W-1:0] count;
    logic             done;

    logic             b_valid;
    logic [31:0]      b_instr;
    logic [CNT_W-1:0] b_count;
    logic             b_done;

    int n_total;
    int n_bad;
    int hs;

    instr_stim_gen #(
        .SEED     (32'd158),
        .NUM_REGS (32),
        .CNT_W    (CNT_W)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .max_count (max_count),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .count     (count),
        .done      (done)
    );

    instr_stim_gen #(
        .SEED     (32'h0002_3FFF),
        .NUM_REGS (32),
        .CNT_W    (CNT_W)
    ) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .max_count (max_count),
        .out_ready (out_ready),
        .out_valid (b_valid),
        .out_instr (b_instr),
        .count     (b_count),
        .done      (b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] m, input logic [CNT_W-1:0] mx);
        mode      = m;
        max_count = mx;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        reset     = 1'b1;
        start     = 1'b0;
        mode      = 2'd0;
        max_count = '0;
        out_ready = 1'b0;

        // Reset held for three cycles.
        tick(); tick(); tick();
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_instr", out_instr, 32'h0000_0013);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        reset = 1'b0;

        // ITYPE first word, plus shift-immediate masking on the second seed.
        do_start(2'd0, '0);
        check_eq("it_valid", 32'(out_valid), 32'd1);
        check_eq("it_first", out_instr, 32'h09E0_0013);
        check_eq("shamt_first", b_instr, 32'h01F1_9013);
        check_eq("b_valid", 32'(b_valid), 32'd1);
        check_eq("b_count", 32'(b_count), 32'd0);
        check_eq("b_done", 32'(b_done), 32'd0);

        // Backpressure: word and count frozen.
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_instr", out_instr, 32'h09E0_0013);
            check_eq("bp_count", 32'(count), 32'd0);
        end

        // Release: LFSR must have advanced exactly once per handshake.
        out_ready = 1'b1;
        tick();
        check_eq("hs1_instr", out_instr, 32'h04F0_0013);
        check_eq("hs1_count", 32'(count), 32'd1);
        tick();
        check_eq("hs2_instr", out_instr, 32'h0240_0113);
        check_eq("hs2_count", 32'(count), 32'd2);

        // Reset mid-run, then restart reproduces the original first word.
        do_reset();
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_count", 32'(count), 32'd0);
        check_eq("mid_rst_instr", out_instr, 32'h0000_0013);
        do_start(2'd0, '0);
        check_eq("restart_first", out_instr, 32'h09E0_0013);

        // RTYPE from the same seed.
        do_reset();
        do_start(2'd1, '0);
        check_eq("rt_first", out_instr, 32'h0000_0033);

        // NOP-only mode.
        do_reset();
        do_start(2'd3, '0);
        check_eq("nop_valid", 32'(out_valid), 32'd1);
        check_eq("nop_instr", out_instr, 32'h0000_0013);

        // MIXED: third state has mixsel=1 and decodes as R-type.
        do_reset();
        do_start(2'd2, '0);
        check_eq("mix_0", out_instr, 32'h09E0_0013);
        tick();
        check_eq("mix_1", out_instr, 32'h04F0_0013);
        tick();
        check_eq("mix_2", out_instr, 32'h0000_0133);

        // Bounded run of three.
        do_reset();
        do_start(2'd0, CNT_W'(3));
        hs = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) break;
            if (out_valid && out_ready) hs++;
            tick();
        end
        check_eq("max3_hs", 32'(hs), 32'd3);
        check_eq("max3_done", 32'(done), 32'd1);
        check_eq("max3_valid", 32'(out_valid), 32'd0);
        check_eq("max3_count", 32'(count), 32'd3);
        check_eq("max3_instr", out_instr, 32'h0000_0013);

        // DONE -> RUN keeps the LFSR where the last run left it.
        out_ready = 1'b0;
        do_start(2'd0, '0);
        check_eq("rerun_valid", 32'(out_valid), 32'd1);
        check_eq("rerun_done", 32'(done), 32'd0);
        check_eq("rerun_count", 32'(count), 32'd0);
        check_eq("rerun_instr", out_instr, 32'h0120_0093);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_stim_gen.md
INSTR_STIM_GEN -- requirements
Module: instr_stim_gen

Interface
REQ-001 SHALL have parameter SEED, default 32'd158: initial LFSR state; a value of 0 SHALL be replaced by 1.
REQ-002 SHALL have parameter NUM_REGS, default 32: register index range; power of two, 2..32.
REQ-003 SHALL have parameter CNT_W, default 16: width of the instruction counter.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on posedge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse that begins a run.
REQ-007 SHALL have port mode  in  2  0 ITYPE, 1 RTYPE, 2 MIXED, 3 NOP-only; sampled at start.
REQ-008 SHALL have port max_count  in  CNT_W  instructions per run; 0 means unlimited; sampled at start.
REQ-009 SHALL have port out_ready  in  1  consumer accepts out_instr.
REQ-010 SHALL have port out_valid  out  1  out_instr holds a generated instruction.
REQ-011 SHALL have port out_instr  out  32  RV32I instruction word.
REQ-012 SHALL have port count  out  CNT_W  handshakes completed in the current run.
REQ-013 SHALL have port done  out  1  high while in DONE.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE: IDLE->RUN on start; RUN->DONE on the handshake that makes count==max_count (max_count!=0); DONE->RUN on start (count cleared, LFSR not reseeded); start in RUN ignored.
REQ-015 SHALL use a 32-bit Galois LFSR, polynomial 0x80200003, advanced exactly once per handshake (out_valid & out_ready) and otherwise held.
REQ-016 SHALL decode fields from LFSR state s: imm=s[11:0], rs1=s[16:12], funct3=s[19:17], rd=s[24:20], rs2=s[29:25], f7sel=s[30], mixsel=s[31]; register fields SHALL be ANDed with NUM_REGS-1.
REQ-017 SHALL form I-type words as {imm,rs1,funct3,rd,7'b0010011}, with imm masked to 12'h01F when funct3==1 and 12'h41F when funct3==5.
REQ-018 SHALL form R-type words as {funct7,rs2,rs1,funct3,rd,7'b0110011}, with funct7=7'h20 when f7sel=1 and funct3 is 0 or 5, else 7'h00.
REQ-019 SHALL select I-type in MIXED mode when mixsel=0 and R-type when mixsel=1; NOP-only mode SHALL emit 32'h00000013.
REQ-020 SHALL assert out_valid from the cycle after start until DONE, with one instruction per cycle when out_ready is held high.
REQ-021 SHALL hold out_instr and out_valid stable while out_valid & !out_ready.
REQ-022 SHALL drive out_instr=32'h00000013 whenever out_valid=0.
REQ-023 SHALL increment count on each handshake, saturating at all-ones when max_count=0.

Reset
REQ-024 SHALL on reset enter IDLE with out_valid=0, out_instr=32'h00000013, count=0, done=0, and LFSR=SEED, overriding any in-progress run or simultaneous start.

Structure
REQ-025 SHALL take opcode constants, the NOP word, the mode encodings and the LFSR polynomial from shared package stim_pkg.
REQ-026 SHALL put the LFSR in sub-module stim_lfsr (ports clk, reset, step, state), leaving decode and the FSM in the top level.

Verification
REQ-027 SHALL verify reset: assert reset for 3 cycles -> out_valid=0, out_instr=0x00000013, count=0.
REQ-028 SHALL verify ITYPE: SEED=158, start with out_ready=1 -> first out_instr=0x09E00013; RTYPE under the same stimulus -> 0x00000033.
REQ-029 SHALL verify shift-immediate masking: SEED=0x00023FFF, ITYPE -> first out_instr=0x01F19013.
REQ-030 SHALL verify backpressure: out_ready=0 for 5 cycles after valid -> out_instr unchanged, count=0, LFSR unchanged.
REQ-031 SHALL verify max_count=3 with out_ready=1 -> exactly 3 handshakes, done=1 and out_valid=0 in the cycle after the third, count=3.
REQ-032 SHALL verify reset mid-run: reset after the 2nd handshake, then start -> first instruction equals the first instruction of the original run.
